// File: rtl/sha256_nonce_scheduler.sv
// Walks a nonce range through one sha256_pipeline and reports every hash below the job target.
// Define SHA_SCHED_HASH_CNT_EN to add a saturating 48-bit hash_count output.
module sha256_nonce_scheduler #(
    parameter int NONCE_LSB      = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [511:0] job_block,
    input  logic [255:0] job_target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         abort,
    output logic         core_start,
    output logic [511:0] core_block,
    input  logic [255:0] core_hash,
    input  logic         core_done,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         exhausted,
    output logic         timeout_err,
    output logic         busy,
`ifdef SHA_SCHED_HASH_CNT_EN
    output logic [47:0]  hash_count,
`endif
    output logic [2:0]   state_dbg
);

    // Job and found channels transfer on the rising edge where valid && ready are both high;
    // the offering side holds valid and its payload steady until that edge.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_FOUND  = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t         state_q, state_n;
    logic [511:0]   blk_q;
    logic [255:0]   target_q;
    logic [255:0]   hash_q;
    logic [31:0]    nonce_q;
    logic [31:0]    end_q;
    logic [15:0]    wd_q;
    logic           exh_q, exh_n, exh_c;
    logic           accept, nonce_inc, hash_take;
    logic           hit, last, wd_expired;

    assign hit        = hash_q < target_q;
    assign last       = nonce_q == end_q;
    assign wd_expired = wd_q == 16'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            blk_q    <= '0;
            target_q <= '0;
            hash_q   <= '0;
            nonce_q  <= '0;
            end_q    <= '0;
            wd_q     <= '0;
            exh_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            exh_q   <= exh_n;
            if (accept) begin
                blk_q    <= job_block;
                target_q <= job_target;
                end_q    <= nonce_end;
                nonce_q  <= nonce_start;
            end
            if (nonce_inc) nonce_q <= nonce_q + 32'd1;
            if (state_q == S_LAUNCH)
                wd_q <= '0;
            else if (state_q == S_WAIT || state_q == S_DRAIN)
                wd_q <= wd_q + 16'd1;
            if (hash_take) hash_q <= core_hash;
        end
    end

    always_comb begin
        state_n     = state_q;
        core_start  = 1'b0;
        timeout_err = 1'b0;
        exh_c       = 1'b0;
        exh_n       = 1'b0;
        accept      = 1'b0;
        nonce_inc   = 1'b0;
        hash_take   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (job_valid) begin
                        accept  = 1'b1;
                        state_n = S_LAUNCH;
                    end
                end
                // An abort here suppresses the start so no core_done can follow.
                S_LAUNCH: begin
                    if (abort) state_n = S_IDLE;
                    else begin
                        core_start = 1'b1;
                        state_n    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort) state_n = S_DRAIN;
                    else if (core_done) begin
                        hash_take = 1'b1;
                        state_n   = S_CHECK;
                    end else if (wd_expired) begin
                        timeout_err = 1'b1;
                        state_n     = S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (abort) state_n = S_IDLE;
                    else if (hit) state_n = S_FOUND;
                    else if (last) begin
                        exh_c   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        nonce_inc = 1'b1;
                        state_n   = S_LAUNCH;
                    end
                end
                // Exhaustion after a hit is reported one cycle later so it never overlaps found_valid.
                S_FOUND: begin
                    if (abort) state_n = S_IDLE;
                    else if (found_ready) begin
                        if (last) begin
                            exh_n   = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            nonce_inc = 1'b1;
                            state_n   = S_LAUNCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (core_done || wd_expired) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        core_block                    = blk_q;
        core_block[NONCE_LSB +: 32]   = nonce_q;
    end

    assign job_ready   = !rst && (state_q == S_IDLE);
    assign busy        = !rst && (state_q != S_IDLE);
    assign found_valid = !rst && (state_q == S_FOUND);
    assign exhausted   = !rst && (exh_c || exh_q);
    assign found_nonce = nonce_q;
    assign found_hash  = hash_q;
    assign state_dbg   = state_q;

`ifdef SHA_SCHED_HASH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            hash_count <= '0;
        else if (hash_take && hash_count != '1)
            hash_count <= hash_count + 48'd1;
    end
`endif

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Bench for sha256_nonce_scheduler: a behavioural core model with programmable done delay and hash,
// directed range/wrap/hit/abort/timeout scenarios and randomized jobs against a reference model.
module tb_sha256_nonce_scheduler;

  localparam int NLSB = 96;
  localparam int TMO  = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [511:0] job_block = '0;
  logic [255:0] job_target = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic         abort = 1'b0;
  logic         core_start;
  logic [511:0] core_block;
  logic [255:0] core_hash = '0;
  logic         core_done = 1'b0;
  logic         found_valid;
  logic         found_ready = 1'b0;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         exhausted;
  logic         timeout_err;
  logic         busy;
  logic [2:0]   state_dbg;
`ifdef SHA_SCHED_HASH_CNT_EN
  logic [47:0]  hash_count;
`endif

  sha256_nonce_scheduler #(.NONCE_LSB(NLSB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_block(job_block), .job_target(job_target), .nonce_start(nonce_start),
    .nonce_end(nonce_end), .abort(abort), .core_start(core_start), .core_block(core_block),
    .core_hash(core_hash), .core_done(core_done), .found_valid(found_valid),
    .found_ready(found_ready), .found_nonce(found_nonce), .found_hash(found_hash),
    .exhausted(exhausted), .timeout_err(timeout_err), .busy(busy),
`ifdef SHA_SCHED_HASH_CNT_EN
    .hash_count(hash_count),
`endif
    .state_dbg(state_dbg)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  // core model configuration
  int           done_dly = 3;
  bit           never_done = 0;
  bit           hit_mode = 0;
  logic [31:0]  hit_nonce = '0;
  logic [255:0] hash_key = '0;
  int           found_hold = 0;

  // observation logs
  logic [31:0]  start_q[$];
  int           start_cyc_q[$];
  int           done_cyc_q[$];
  logic [511:0] blk_log[$];
  logic [31:0]  fn_q[$];
  logic [255:0] fh_q[$];
  int           fv_cyc_q[$];
  int exh_cnt, tmo_cnt, exh_cyc, tmo_cyc, fv_cycles;
  int excl_err = 0;
  int blk_unstable = 0;
  int hold, cnt, acc_cyc;
  bit fv_seen, pend, ready_after;
  logic [31:0]  cur_nonce;
  logic [511:0] start_blk, cur_block;

  // scoreboard expectations
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_hit_q[$];

  function automatic logic [255:0] model_hash(logic [31:0] n);
    if (hit_mode)
      return (n == hit_nonce) ? {32'h0, hash_key[223:0]} : {32'hFFFF_FFFF, hash_key[223:0]};
    return {(n * 32'h9E37_79B1) ^ hash_key[255:224], hash_key[223:0]};
  endfunction

  function automatic logic [511:0] with_nonce(logic [511:0] b, logic [31:0] n);
    logic [511:0] r;
    r = b;
    r[NLSB +: 32] = n;
    return r;
  endfunction

  // core model, event monitor and found consumer, all sampled mid-cycle
  always @(negedge clk) begin
    core_done = 1'b0;
    if (rst) begin
      pend = 0;
      found_ready = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          pend = 0;
          if (!never_done) begin
            core_done = 1'b1;
            core_hash = model_hash(cur_nonce);
            done_cyc_q.push_back(cyc);
            if (core_block !== start_blk) blk_unstable++;
          end
        end else cnt--;
      end
      if (core_start) begin
        pend = 1;
        cnt = done_dly - 1;
        cur_nonce = core_block[NLSB +: 32];
        start_blk = core_block;
        start_q.push_back(cur_nonce);
        start_cyc_q.push_back(cyc);
        blk_log.push_back(core_block);
      end
      if (exhausted) begin exh_cnt++; exh_cyc = cyc; end
      if (timeout_err) begin tmo_cnt++; tmo_cyc = cyc; end
      if (int'(found_valid) + int'(exhausted) + int'(timeout_err) > 1) excl_err++;
      if (found_ready) begin
        found_ready = 1'b0;
        hold = found_hold;
      end else if (found_valid) begin
        fv_cycles++;
        if (!fv_seen) begin fv_seen = 1; fv_cyc_q.push_back(cyc); end
        if (hold == 0) begin
          found_ready = 1'b1;
          fn_q.push_back(found_nonce);
          fh_q.push_back(found_hash);
          fv_seen = 0;
        end else hold--;
      end else fv_seen = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    start_q.delete(); start_cyc_q.delete(); done_cyc_q.delete(); blk_log.delete();
    fn_q.delete(); fh_q.delete(); fv_cyc_q.delete(); exp_q.delete(); exp_hit_q.delete();
    exh_cnt = 0; tmo_cnt = 0; fv_cycles = 0; hold = found_hold; fv_seen = 0;
  endtask

  // reference: every nonce from s to e inclusive (with 32-bit wrap) and those whose hash is below t
  task automatic build_expected(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t);
    logic [31:0] n;
    n = s;
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back(n);
      if (model_hash(n) < t) exp_hit_q.push_back(n);
      if (n == e) break;
      n = n + 32'd1;
    end
  endtask

  task automatic offer_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t);
    int n;
    cur_block = {16{$urandom()}} ^ {$urandom(), $urandom(), $urandom(), $urandom(), 384'h0};
    n = 0;
    while (!job_ready && n < 100) begin step(); n++; end
    job_valid = 1'b1; job_block = cur_block; job_target = t;
    nonce_start = s; nonce_end = e; acc_cyc = cyc;
    step();
    job_valid = 1'b0; job_block = ~cur_block; nonce_start = $urandom(); nonce_end = $urandom();
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t,
                         input int max_cyc);
    int n;
    clear_logs();
    build_expected(s, e, t);
    offer_job(s, e, t);
    n = 0;
    while (exh_cnt == 0 && tmo_cnt == 0 && n < max_cyc) begin step(); n++; end
    step();
    ready_after = job_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++;
    if ({job_ready, busy, core_start, found_valid, exhausted, timeout_err} !== 6'b0 || core_block !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ctl=%b core_block_zero=%b, want 000000 and 1",
               {job_ready, busy, core_start, found_valid, exhausted, timeout_err}, core_block == '0);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: job_ready=%b busy=%b, want 1 0", job_ready, busy);
    end
  endtask

  task automatic test_single_hit();
    hit_mode = 0; done_dly = 3; found_hold = 0;
    run_job(32'd5, 32'd5, '1, 200);
    vectors++;
    if (start_q.size() != 1 || start_q[0] !== 32'd5 || blk_log[0] !== with_nonce(cur_block, 32'd5)) begin
      miscompares++;
      $display("FAIL single_launch: starts=%0d nonce=%h, want 1 start nonce 00000005 in field", start_q.size(), start_q[0]);
    end
    vectors++;
    if (fn_q.size() != 1 || fn_q[0] !== 32'd5 || fh_q[0] !== model_hash(32'd5)) begin
      miscompares++;
      $display("FAIL single_found: hits=%0d nonce=%h hash=%h, want 1 00000005 %h", fn_q.size(), fn_q[0], fh_q[0], model_hash(32'd5));
    end
    vectors++;
    if (exh_cnt != 1 || start_cyc_q[0] != acc_cyc + 1 || fv_cyc_q[0] != done_cyc_q[0] + 2) begin
      miscompares++;
      $display("FAIL single_timing: exh=%0d start@%0d found@%0d, want 1 start@%0d found@%0d",
               exh_cnt, start_cyc_q[0], fv_cyc_q[0], acc_cyc + 1, done_cyc_q[0] + 2);
    end
  endtask

  task automatic test_range_miss(input logic [31:0] s, input logic [31:0] e, input string tag);
    int lat_err;
    hit_mode = 0; done_dly = $urandom_range(1, 5); found_hold = 0;
    run_job(s, e, '0, 300);
    vectors++;
    if (start_q != exp_q) begin
      miscompares++;
      $display("FAIL %s_nonces: got %0d starts first=%h, want %0d starts first=%h", tag, start_q.size(), start_q[0], exp_q.size(), exp_q[0]);
    end
    lat_err = 0;
    for (int i = 1; i < start_cyc_q.size(); i++)
      if (start_cyc_q[i] != done_cyc_q[i-1] + 2) lat_err++;
    vectors++;
    if (exh_cnt != 1 || fn_q.size() != 0 || ready_after !== 1'b1 || lat_err != 0) begin
      miscompares++;
      $display("FAIL %s_end: exh=%0d hits=%0d ready=%b lat_err=%0d, want 1 0 1 0", tag, exh_cnt, fn_q.size(), ready_after, lat_err);
    end
  endtask

  task automatic test_found_hold();
    hit_mode = 1; hit_nonce = 32'd2; done_dly = 4; found_hold = 10;
    run_job(32'd0, 32'd4, {32'h1, 224'h0}, 400);
    vectors++;
    if (start_q != exp_q || fn_q.size() != 1 || fn_q[0] !== 32'd2) begin
      miscompares++;
      $display("FAIL hold_sequence: starts=%0d hits=%0d hit_nonce=%h, want 5 1 00000002", start_q.size(), fn_q.size(), fn_q[0]);
    end
    vectors++;
    if (fv_cycles != 11 || fv_cyc_q[0] != done_cyc_q[2] + 2 || exh_cnt != 1) begin
      miscompares++;
      $display("FAIL hold_timing: valid_cycles=%0d found@%0d exh=%0d, want 11 @%0d 1", fv_cycles, fv_cyc_q[0], exh_cnt, done_cyc_q[2] + 2);
    end
    hit_mode = 0; found_hold = 0;
  endtask

  task automatic test_equal_target();
    logic [255:0] h;
    hit_mode = 0; done_dly = 2; found_hold = 0;
    h = model_hash(32'd7);
    run_job(32'd7, 32'd7, h, 200);
    vectors++;
    if (fn_q.size() != 0 || exh_cnt != 1) begin
      miscompares++;
      $display("FAIL equal_is_miss: hits=%0d exh=%0d, want 0 1", fn_q.size(), exh_cnt);
    end
    run_job(32'd7, 32'd7, h + 256'd1, 200);
    vectors++;
    if (fn_q.size() != 1 || fh_q[0] !== h || exh_cnt != 1) begin
      miscompares++;
      $display("FAIL just_above_hits: hits=%0d exh=%0d, want 1 1", fn_q.size(), exh_cnt);
    end
  endtask

  task automatic test_abort();
    int n, rdy_cyc;
    hit_mode = 0; done_dly = 14; found_hold = 0;
    clear_logs();
    offer_job(32'd0, 32'd3, '0);
    n = 0;
    while (start_q.size() == 0 && n < 20) begin step(); n++; end
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    rdy_cyc = -1;
    for (int i = 0; i < 60 && rdy_cyc < 0; i++) begin
      if (job_ready) rdy_cyc = cyc;
      else step();
    end
    repeat (4) step();
    vectors++;
    if (done_cyc_q.size() != 1 || rdy_cyc != done_cyc_q[0] + 1) begin
      miscompares++;
      $display("FAIL abort_drain: dones=%0d ready@%0d, want 1 ready@%0d", done_cyc_q.size(), rdy_cyc, done_cyc_q[0] + 1);
    end
    vectors++;
    if (start_q.size() != 1 || exh_cnt != 0 || fn_q.size() != 0 || tmo_cnt != 0) begin
      miscompares++;
      $display("FAIL abort_silent: starts=%0d exh=%0d hits=%0d tmo=%0d, want 1 0 0 0", start_q.size(), exh_cnt, fn_q.size(), tmo_cnt);
    end
  endtask

  task automatic test_timeout();
    hit_mode = 0; never_done = 1; found_hold = 0;
    run_job(32'd10, 32'd12, '0, 200);
    never_done = 0;
    vectors++;
    if (tmo_cnt != 1 || tmo_cyc != start_cyc_q[0] + TMO || start_q.size() != 1 || exh_cnt != 0 || ready_after !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout: tmo=%0d @%0d starts=%0d exh=%0d ready=%b, want 1 @%0d 1 0 1",
               tmo_cnt, tmo_cyc, start_q.size(), exh_cnt, ready_after, start_cyc_q[0] + TMO);
    end
    done_dly = 2;
    run_job(32'd20, 32'd21, '0, 200);
    vectors++;
    if (start_q != exp_q || exh_cnt != 1 || tmo_cnt != 0) begin
      miscompares++;
      $display("FAIL after_timeout: starts=%0d exh=%0d tmo=%0d, want 2 1 0", start_q.size(), exh_cnt, tmo_cnt);
    end
  endtask

  task automatic test_random_jobs();
    logic [31:0] s, e;
    logic [255:0] t;
    int len, lat_err, hi;
    hit_mode = 0;
    for (int j = 0; j < 8; j++) begin
      s = $urandom(); len = $urandom_range(0, 5); e = s + 32'(len);
      if (j == 0) begin s = 32'hFFFF_FFFD; e = 32'h0000_0001; end
      hash_key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      done_dly = $urandom_range(1, 8); found_hold = $urandom_range(0, 3);
      run_job(s, e, t, 600);
      vectors++;
      if (start_q != exp_q || fn_q != exp_hit_q || exh_cnt != 1 || tmo_cnt != 0) begin
        miscompares++;
        $display("FAIL random_job%0d: starts=%0d/%0d hits=%0d/%0d exh=%0d tmo=%0d", j,
                 start_q.size(), exp_q.size(), fn_q.size(), exp_hit_q.size(), exh_cnt, tmo_cnt);
      end
      lat_err = 0; hi = 0;
      for (int i = 0; i < exp_q.size() && i < start_q.size(); i++) begin
        if (blk_log[i] !== with_nonce(cur_block, exp_q[i])) lat_err++;
        if (hi < exp_hit_q.size() && exp_hit_q[hi] == exp_q[i]) begin
          if (fv_cyc_q[hi] != done_cyc_q[i] + 2 || fh_q[hi] !== model_hash(exp_q[i])) lat_err++;
          hi++;
        end else if (i + 1 < start_q.size() && start_cyc_q[i+1] != done_cyc_q[i] + 2) lat_err++;
      end
      vectors++;
      if (lat_err != 0) begin
        miscompares++;
        $display("FAIL random_detail%0d: %0d block/latency/hash errors, want 0", j, lat_err);
      end
    end
    found_hold = 0;
  endtask

  initial begin
    hash_key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    hash_key[0] = 1'b0;
    test_reset();
    test_single_hit();
    test_range_miss(32'd0, 32'd3, "range");
    test_range_miss(32'hFFFF_FFFE, 32'd1, "wrap");
    test_found_hold();
    test_equal_target();
    test_abort();
    test_timeout();
    test_random_jobs();
    vectors++;
    if (excl_err != 0 || blk_unstable != 0) begin
      miscompares++;
      $display("FAIL global: overlap_cycles=%0d block_changes=%0d, want 0 0", excl_err, blk_unstable);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
